// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the external loader/debug master and the data memory.
// slave is the arbiter's view; master is the surrounding environment's view.
interface dmem_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  core_rd;
  logic                  core_wr;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_funct3;
  logic [DATA_W-1:0]     core_rdata;
  logic                  core_stall;

  logic                  ext_req;
  logic                  ext_we;
  logic                  ext_lock;
  logic [DM_ADDRESS-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [2:0]            ext_funct3;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_W-1:0]     ext_rdata;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  logic [2:0]            starve_cnt;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, core_funct3,
    output core_rdata, core_stall,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata, ext_funct3,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata,
    output starve_cnt
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata, core_funct3,
    input  core_rdata, core_stall,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata, ext_funct3,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata,
    input  starve_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core has priority, ext gets a starvation bound
// and locked bursts of up to BURST_MAX beats, followed by one guaranteed core slot.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {ARB, EXT_BURST, CORE_PAY} state_t;

  state_t          state;
  logic [BW-1:0]   burst_cnt;
  logic [BW-1:0]   burst_nxt;
  logic [2:0]      starve;
  logic            core_req;
  logic            gnt;
  logic            core_gnt;
  logic            ext_rd_gnt;

  assign core_req   = bus.core_rd | bus.core_wr;
  assign burst_nxt  = burst_cnt + 1'b1;
  assign ext_rd_gnt = gnt & ~bus.ext_we;

  always_comb begin
    gnt = 1'b0;
    case (state)
      ARB:       gnt = bus.ext_req & (~core_req | (starve == 3'(STARVE_MAX)));
      EXT_BURST: gnt = bus.ext_req;
      CORE_PAY:  gnt = bus.ext_req & ~core_req;
      default:   gnt = 1'b0;
    endcase
    if (!reset) gnt = 1'b0;
  end

  assign core_gnt       = reset & core_req & ~gnt;
  assign bus.ext_gnt    = gnt;
  assign bus.core_stall = core_req & gnt;
  assign bus.starve_cnt = starve;
  // A simultaneous rd+wr from the core is a store, so no load data is returned.
  assign bus.core_rdata = (core_gnt & bus.core_rd & ~bus.core_wr) ? bus.mem_rdata : '0;

  always_comb begin
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_funct3 = '0;
    if (gnt) begin
      bus.mem_rd     = ~bus.ext_we;
      bus.mem_wr     = bus.ext_we;
      bus.mem_addr   = bus.ext_addr;
      bus.mem_wdata  = bus.ext_wdata;
      bus.mem_funct3 = bus.ext_funct3;
    end else if (core_gnt) begin
      bus.mem_rd     = bus.core_rd & ~bus.core_wr;
      bus.mem_wr     = bus.core_wr;
      bus.mem_addr   = bus.core_addr;
      bus.mem_wdata  = bus.core_wdata;
      bus.mem_funct3 = bus.core_funct3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ARB;
      burst_cnt      <= '0;
      starve         <= '0;
      bus.ext_rvalid <= 1'b0;
      bus.ext_rdata  <= '0;
    end else begin
      bus.ext_rvalid <= ext_rd_gnt;
      if (ext_rd_gnt) bus.ext_rdata <= bus.mem_rdata;

      if (!bus.ext_req || gnt)              starve <= '0;
      else if (starve != 3'(STARVE_MAX))    starve <= starve + 3'd1;

      case (state)
        ARB: begin
          if (gnt && bus.ext_lock) begin
            state     <= EXT_BURST;
            burst_cnt <= BW'(1);
          end else if (gnt && core_req) begin
            state <= CORE_PAY;
          end
        end
        EXT_BURST: begin
          if (gnt) burst_cnt <= burst_nxt;
          // The core always gets one slot after a burst, however it ended.
          if (!bus.ext_lock || !bus.ext_req || (gnt && burst_nxt == BW'(BURST_MAX))) begin
            state     <= CORE_PAY;
            burst_cnt <= '0;
          end
        end
        CORE_PAY: state <= ARB;
        default:  state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected load/read data into
// queues, a negedge monitor pops them whenever the DUT presents data.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW), .DM_ADDRESS(AW)) bus();

  dmem_arbiter #(.DATA_W(DW), .DM_ADDRESS(AW), .STARVE_MAX(4), .BURST_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory model: combinational read, write on the clock edge.
  logic [DW-1:0] mem [0:511];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (pre_we)          mem[pre_a] <= pre_d;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] core_q[$];
  logic [DW-1:0] ext_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic core(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.core_rd = rd; bus.core_wr = wr; bus.core_addr = a; bus.core_wdata = d; bus.core_funct3 = 3'b010;
  endtask

  task automatic ext(input logic rq, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ext_req = rq; bus.ext_we = we; bus.ext_lock = lk; bus.ext_addr = a; bus.ext_wdata = d; bus.ext_funct3 = 3'b010;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.ext_rvalid === 1'b1) begin
          if (ext_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL ext_rvalid_unexpected: got rvalid with data %h, expected none", bus.ext_rdata);
          end else chk("ext_rdata", bus.ext_rdata, ext_q.pop_front());
        end
        if (bus.core_rd === 1'b1 && bus.core_wr === 1'b0 && bus.core_stall === 1'b0) begin
          if (core_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL core_load_unexpected: got load data %h, expected none", bus.core_rdata);
          end else chk("core_rdata", bus.core_rdata, core_q.pop_front());
        end
      end
    end
  end

  initial begin
    int b;
    reset = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    core(0, 0, 0, 0); ext(0, 0, 0, 0, 0);
    tick();
    preload(9'h020, 32'h1234_5020);
    preload(9'h021, 32'h2121_2121);
    preload(9'h030, 32'h3030_3030);
    preload(9'h031, 32'h3131_3131);
    preload(9'h032, 32'h3232_3232);
    preload(9'h040, 32'h4040_4040);

    // Reset: outputs forced low even with requests present
    core(1, 0, 9'h040, 0); ext(1, 0, 1, 9'h020, 0); #2;
    chk("rst_gnt", bus.ext_gnt, 0);
    chk("rst_stall", bus.core_stall, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_rvalid", bus.ext_rvalid, 0);
    chk("rst_starve", bus.starve_cnt, 0);
    chk("rst_core_rdata", bus.core_rdata, 0);
    core(0, 0, 0, 0); ext(0, 0, 0, 0, 0);
    tick(); reset = 1'b1;

    // 1: core store then load, ext idle
    core(0, 1, 9'h010, 32'hDEAD_BEEF); #2;
    chk("t1_mem_wr", bus.mem_wr, 1);
    chk("t1_mem_addr", bus.mem_addr, 9'h010);
    chk("t1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t1_gnt", bus.ext_gnt, 0);
    chk("t1_stall", bus.core_stall, 0);
    tick();
    core(1, 0, 9'h010, 0); core_q.push_back(32'hDEAD_BEEF); #2;
    chk("t1_mem_rd", bus.mem_rd, 1);
    chk("t1_stall2", bus.core_stall, 0);
    tick();
    core(0, 0, 0, 0);

    // 2: starvation forces ext in on the 5th cycle, then core gets its slot
    for (int i = 0; i < 4; i++) begin
      core(1, 0, 9'h040, 0); ext(1, 0, 0, 9'h020, 0); core_q.push_back(32'h4040_4040); #2;
      chk("t2_starve", bus.starve_cnt, i);
      chk("t2_gnt_denied", bus.ext_gnt, 0);
      tick();
    end
    #2;
    chk("t2_starve_max", bus.starve_cnt, 4);
    chk("t2_forced_gnt", bus.ext_gnt, 1);
    chk("t2_forced_stall", bus.core_stall, 1);
    chk("t2_mem_addr", bus.mem_addr, 9'h020);
    ext_q.push_back(32'h1234_5020);
    tick();
    ext(0, 0, 0, 0, 0); core_q.push_back(32'h4040_4040); #2;
    chk("t2_pay_gnt", bus.ext_gnt, 0);
    chk("t2_pay_stall", bus.core_stall, 0);
    chk("t2_pay_rvalid", bus.ext_rvalid, 1);
    chk("t2_pay_addr", bus.mem_addr, 9'h040);
    tick();
    core(0, 0, 0, 0);

    // 3: locked write burst with core idle; every beat is granted
    for (int i = 0; i < 10; i++) begin
      ext(1, 1, 1, AW'(i), 32'hA0 + i); #2;
      chk("t3_gnt", bus.ext_gnt, 1);
      chk("t3_starve", bus.starve_cnt, 0);
      chk("t3_mem_wr", bus.mem_wr, 1);
      tick();
    end
    ext(0, 0, 0, 0, 0); tick();
    core(1, 0, 9'h009, 0); core_q.push_back(32'hA9); #2;
    chk("t3_rd_stall", bus.core_stall, 0);
    tick();
    core(0, 0, 0, 0);

    // 4: core load arrives mid-burst; stalled until the 8-beat limit, served in CORE_PAY
    b = 0;
    for (int c = 0; c < 10; c++) begin
      core((c >= 2 && c <= 8), 0, 9'h010, 0);
      if (c == 8) core_q.push_back(32'hDEAD_BEEF);
      ext(1, 1, 1, AW'(9'h100 + b), 32'hB000 + b); #2;
      chk("t4_gnt", bus.ext_gnt, 32'(c != 8));
      chk("t4_stall", bus.core_stall, 32'(c >= 2 && c <= 7));
      if (c == 8) chk("t4_pay_addr", bus.mem_addr, 9'h010);
      if (c != 8) b++;
      tick();
    end
    core(0, 0, 0, 0); ext(0, 0, 0, 0, 0); tick(); tick();
    core(1, 0, 9'h108, 0); core_q.push_back(32'hB008); tick();
    core(0, 0, 0, 0);

    // 5: reset mid-burst with a read in flight
    ext(1, 0, 1, 9'h020, 0); ext_q.push_back(32'h1234_5020); #2;
    chk("t5_gnt0", bus.ext_gnt, 1);
    tick();
    ext(1, 0, 1, 9'h021, 0); #2;
    chk("t5_gnt1", bus.ext_gnt, 1);
    tick();
    reset = 1'b0; #2;
    chk("t5_rvalid_drop", bus.ext_rvalid, 0);
    chk("t5_rdata_clr", bus.ext_rdata, 0);
    chk("t5_gnt_rst", bus.ext_gnt, 0);
    tick(); tick();
    reset = 1'b1;
    core(1, 0, 9'h010, 0); core_q.push_back(32'hDEAD_BEEF); #2;
    chk("t5_post_stall", bus.core_stall, 0);
    chk("t5_post_gnt", bus.ext_gnt, 0);
    chk("t5_post_addr", bus.mem_addr, 9'h010);
    tick();
    core(0, 0, 0, 0); ext(0, 0, 0, 0, 0); tick();

    // 6: ext reads with core idle, single then back-to-back
    ext(1, 0, 0, 9'h030, 0); ext_q.push_back(32'h3030_3030); #2;
    chk("t6_gnt", bus.ext_gnt, 1);
    tick();
    ext(0, 0, 0, 0, 0); #2;
    chk("t6_rvalid1", bus.ext_rvalid, 1);
    tick(); #2;
    chk("t6_rvalid_once", bus.ext_rvalid, 0);
    chk("t6_rdata_hold", bus.ext_rdata, 32'h3030_3030);
    tick();
    ext(1, 0, 0, 9'h031, 0); ext_q.push_back(32'h3131_3131); #2;
    chk("t6_gnt_a", bus.ext_gnt, 1);
    tick();
    ext(1, 0, 0, 9'h032, 0); ext_q.push_back(32'h3232_3232); #2;
    chk("t6_gnt_b", bus.ext_gnt, 1);
    chk("t6_rvalid_a", bus.ext_rvalid, 1);
    tick();
    ext(0, 0, 0, 0, 0); #2;
    chk("t6_rvalid_b", bus.ext_rvalid, 1);
    tick(); #2;
    chk("t6_rvalid_end", bus.ext_rvalid, 0);
    chk("t6_rdata_last", bus.ext_rdata, 32'h3232_3232);
    tick();

    // 7: core rd+wr together behaves as a store
    core(1, 1, 9'h050, 32'h55); #2;
    chk("t7_mem_wr", bus.mem_wr, 1);
    chk("t7_mem_rd", bus.mem_rd, 0);
    chk("t7_core_rdata", bus.core_rdata, 0);
    tick();
    core(0, 0, 0, 0); tick();

    chk("ext_q_drained", ext_q.size(), 0);
    chk("core_q_drained", core_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
